// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master transfer sequencer:
//   - spi_state_e    : transfer FSM state encoding
//   - SPI_DATA_W_DEF : default transfer word width
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// ---------------------------------------------------------------------------
// spi_shift_reg
// Transmit/receive shift registers and bit counter for one SPI word.
// Ports:
//   PCLK, PRESET  : clock, synchronous active-high reset
//   load          : parallel load of load_data, clears counter and rx word
//   load_data     : word to transmit
//   lsbfe         : 1 = LSB first, 0 = MSB first
//   cphase        : clock phase; 1 = first shift strobe of a word is skipped
//   sample_en     : qualified sampling strobe (captures miso, counts a bit)
//   shift_en      : qualified shifting strobe (advances mosi)
//   miso          : serial input
//   mosi          : serial output (registered)
//   rx_word       : receive shift register contents
//   last_sample   : sample_en on the final bit of the word
// ---------------------------------------------------------------------------
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              lsbfe,
    input  logic              cphase,
    input  logic              sample_en,
    input  logic              shift_en,
    input  logic              miso,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_word,
    output logic              last_sample
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] tx_sr_reg;
    logic [DATA_W-1:0] rx_sr_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic              mosi_reg;
    logic              first_shift_reg;

    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_shifted;
    logic              advance;

    assign tx_shifted = lsbfe ? (tx_sr_reg >> 1) : (tx_sr_reg << 1);
    assign rx_shifted = lsbfe ? {miso, rx_sr_reg[DATA_W-1:1]}
                              : {rx_sr_reg[DATA_W-2:0], miso};

    // With cphase=1 the first bit is already on mosi before the first
    // shifting edge, so that edge must not advance the register. Shift
    // edges after the word is complete are dropped.
    assign advance = shift_en
                  && (bit_cnt_reg < BIT_W'(DATA_W))
                  && !(cphase && first_shift_reg);

    assign last_sample = sample_en && (bit_cnt_reg == BIT_W'(DATA_W - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_sr_reg       <= '0;
            rx_sr_reg       <= '0;
            bit_cnt_reg     <= '0;
            mosi_reg        <= 1'b0;
            first_shift_reg <= 1'b0;
        end else if (load) begin
            tx_sr_reg       <= load_data;
            rx_sr_reg       <= '0;
            bit_cnt_reg     <= '0;
            first_shift_reg <= 1'b1;
            mosi_reg        <= lsbfe ? load_data[0] : load_data[DATA_W-1];
        end else begin
            // Sampling uses rx state only, so a coincident shift cannot
            // disturb it.
            if (sample_en) begin
                rx_sr_reg   <= rx_shifted;
                bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            end
            if (shift_en) begin
                first_shift_reg <= 1'b0;
            end
            if (advance) begin
                tx_sr_reg <= tx_shifted;
                mosi_reg  <= lsbfe ? tx_shifted[0] : tx_shifted[DATA_W-1];
            end
        end
    end

    assign mosi    = mosi_reg;
    assign rx_word = rx_sr_reg;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl
// SPI master transfer sequencer: qualifies a request, drives slave select
// with setup/hold timing, gates the baud generator and runs the word shift.
// Ports:
//   PCLK, PRESET           : clock, synchronous active-high reset
//   spe, mstr, spiswai     : enable, master select, stop-in-wait freeze
//   cphase, lsbfe          : clock phase and bit order
//   start, tx_data         : transfer request and word to send
//   sample_stb, shift_stb  : SCLK edge strobes from the baud generator
//   miso / mosi            : serial data in / out
//   spif_clr               : clears spif
//   baud_en                : baud generator enable
//   ss                     : slave select, active-low
//   busy                   : any state other than IDLE
//   rx_data, rx_valid      : received word and one-cycle update pulse
//   spif                   : sticky transfer-complete flag
// ---------------------------------------------------------------------------
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W    = SPI_DATA_W_DEF,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              spe,
    input  logic              mstr,
    input  logic              spiswai,
    input  logic              cphase,
    input  logic              lsbfe,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              sample_stb,
    input  logic              shift_stb,
    input  logic              miso,
    input  logic              spif_clr,
    output logic              baud_en,
    output logic              ss,
    output logic              mosi,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              spif
);

    spi_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cyc_cnt_reg, cyc_cnt_next;
    logic [DATA_W-1:0] rx_data_reg, rx_data_next;
    logic              rx_valid_reg, rx_valid_next;
    logic              spif_reg, spif_next;

    logic              qual;
    logic              load;
    logic              sample_en;
    logic              shift_en;
    logic              enter_done;
    logic              last_sample;
    logic [DATA_W-1:0] rx_word;

    assign qual = spe && mstr;

    spi_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .load        (load),
        .load_data   (tx_data),
        .lsbfe       (lsbfe),
        .cphase      (cphase),
        .sample_en   (sample_en),
        .shift_en    (shift_en),
        .miso        (miso),
        .mosi        (mosi),
        .rx_word     (rx_word),
        .last_sample (last_sample)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            cyc_cnt_reg  <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            spif_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cyc_cnt_reg  <= cyc_cnt_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            spif_reg     <= spif_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cyc_cnt_next = cyc_cnt_reg;
        load         = 1'b0;
        sample_en    = 1'b0;
        shift_en     = 1'b0;
        enter_done   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && qual && !spiswai) begin
                    state_next   = SETUP;
                    cyc_cnt_next = '0;
                    load         = 1'b1;
                end
            end
            SETUP: begin
                if (!qual) begin
                    state_next = IDLE;
                end else if (!spiswai) begin
                    if (cyc_cnt_reg == CNT_W'(SETUP_CYC - 1)) begin
                        state_next   = XFER;
                        cyc_cnt_next = '0;
                    end else begin
                        cyc_cnt_next = cyc_cnt_reg + CNT_W'(1);
                    end
                end
            end
            XFER: begin
                if (!qual) begin
                    state_next = IDLE;
                end else if (!spiswai) begin
                    sample_en = sample_stb;
                    shift_en  = shift_stb;
                    if (last_sample) begin
                        state_next   = HOLD;
                        cyc_cnt_next = '0;
                    end
                end
            end
            HOLD: begin
                if (!qual) begin
                    state_next = IDLE;
                end else if (!spiswai) begin
                    if (cyc_cnt_reg == CNT_W'(HOLD_CYC - 1)) begin
                        state_next = DONE;
                        enter_done = 1'b1;
                    end else begin
                        cyc_cnt_next = cyc_cnt_reg + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Completion results are registered on the edge entering DONE so they
    // are visible during the DONE cycle itself.
    always_comb begin
        rx_data_next  = enter_done ? rx_word : rx_data_reg;
        rx_valid_next = enter_done;
        // Setting dominates: a clear coincident with entering DONE or
        // arriving during DONE leaves the flag set.
        if (enter_done || (state_reg == DONE)) begin
            spif_next = 1'b1;
        end else if (spif_clr) begin
            spif_next = 1'b0;
        end else begin
            spif_next = spif_reg;
        end
    end

    assign baud_en  = (state_reg == XFER) && !spiswai;
    assign ss       = !((state_reg == SETUP) || (state_reg == XFER) || (state_reg == HOLD));
    assign busy     = (state_reg != IDLE);
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign spif     = spif_reg;

endmodule
